// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction prefetch front-end.
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DROP} pf_state_t;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/pf_fifo.sv
// pf_fifo: circular synchronous FIFO with push/pop/flush and occupancy count.
module pf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    assign rdata = mem[rd];
    assign full = count[AW];
    assign empty = count == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr <= rd;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr] <= wdata;
                wr <= wr + 1'b1;
            end
            if (pop) rd <= rd + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction fetcher with one outstanding memory request,
// a small {pc, instr} queue toward decode, and redirect flush/drop handling.
module instr_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int CW = $clog2(DEPTH) + 1;
    pf_state_t state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [CW-1:0] count;
    logic [63:0] head;
    logic full, empty, push, pop, ack, free_idle, free_push, load;
    assign mem_req = state != IDLE;
    // Acks arriving with no request outstanding (e.g. after reset) are ignored.
    assign ack = mem_ack & mem_req;
    assign instr_valid = !empty;
    assign pop = instr_valid & instr_ready;
    assign push = (state == REQ) & ack & !redirect_valid;
    assign free_idle = !full | pop;
    assign free_push = pop | (count < CW'(DEPTH - 1));
    assign {instr_pc, instr} = head;
    assign fetch_pc_n = redirect_valid ? {redirect_pc[31:2], 2'b00} :
                        push ? fetch_pc + 32'(WORD_BYTES) : fetch_pc;
    // mem_addr only reloads when a fresh request starts, so it stays put while one is pending.
    assign load = (state_n == REQ) && (state == IDLE || ack);
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = (redirect_valid || free_idle) ? REQ : IDLE;
            REQ:     state_n = redirect_valid ? (ack ? REQ : DROP) : (!ack || free_push) ? REQ : IDLE;
            DROP:    state_n = ack ? REQ : DROP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fetch_pc <= RESET_PC;
            mem_addr <= RESET_PC;
        end else begin
            state <= state_n;
            fetch_pc <= fetch_pc_n;
            if (load) mem_addr <= fetch_pc_n;
        end
    end
    pf_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .flush(redirect_valid),
        .wdata({fetch_pc, mem_rdata}),
        .rdata(head),
        .count(count),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_instr_prefetch_queue;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst, redirect_valid, mem_req, mem_ack, instr_valid, instr_ready;
    logic [31:0] redirect_pc, mem_addr, mem_rdata, instr, instr_pc;
    int errors = 0, checks = 0, idle_run = 0, acc_total = 0;
    logic [63:0] q[$];
    logic [31:0] acc_q[$];
    logic [31:0] model_pc, exp_addr, prev_addr, rp;
    bit drop, exp_v, prev_req;

    always #5 clk = ~clk;

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] acc_at(input int i);
        return (acc_q.size() > i) ? acc_q[i] : 32'hDEAD_BEEF;
    endfunction

    // am: 0 no ack, 1 ack if a request is up, 2 ack unconditionally (stray)
    task automatic cyc(input bit r, input bit rv, input logic [31:0] rpc, input int am, input bit rdy);
        bit a, ae, p;
        a = (am == 2) || (am == 1 && mem_req);
        ae = a && mem_req;
        p = rdy && q.size() != 0;
        rst = r; redirect_valid = rv; redirect_pc = rpc; mem_ack = a; mem_rdata = $urandom; instr_ready = rdy;
        exp_v = 0;
        if (r) begin
            q.delete(); model_pc = 32'h0; drop = 0;
        end else if (rv) begin
            if (ae) drop = 0;
            else if (mem_req) drop = 1;
            q.delete();
            model_pc = {rpc[31:2], 2'b00};
        end else begin
            if (p) void'(q.pop_front());
            if (ae) begin
                if (drop) drop = 0;
                else begin
                    exp_v = 1; exp_addr = model_pc;
                    acc_q.push_back(mem_addr); acc_total++;
                    q.push_back({model_pc, mem_rdata});
                    model_pc += 32'd4;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        repeat (n) cyc(1, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("instr_pc", instr_pc, q[0][63:32]);
                chk("instr", instr, q[0][31:0]);
            end
            if (mem_req) chk("req_when_full", 32'(q.size() < DEPTH), 1);
            if (prev_req && !mem_ack) begin
                chk("req_held", 32'(mem_req), 1);
                chk("addr_held", mem_addr, prev_addr);
            end
            if (exp_v) chk("fetch_addr", prev_addr, exp_addr);
            idle_run = (!mem_req && q.size() < DEPTH) ? idle_run + 1 : 0;
            chk("no_stall", 32'(idle_run <= 2), 1);
        end else idle_run = 0;
        prev_req = mem_req;
        prev_addr = mem_addr;
    end

    initial begin
        rst = 1; redirect_valid = 0; redirect_pc = 0; mem_ack = 0; mem_rdata = 0; instr_ready = 0;
        model_pc = 0; drop = 0; exp_v = 0; prev_req = 0; prev_addr = 0; exp_addr = 0;
        @(negedge clk);
        do_reset(3);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        // sequential streaming
        acc_q.delete();
        repeat (14) cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) chk("t1_addr", acc_at(i), 32'(4 * i));
        chk("t1_head", instr_pc, 32'd48);
        chk("t1_next_addr", mem_addr, 32'd52);
        // fill with decode stalled
        do_reset(1); acc_q.delete();
        repeat (20) cyc(0, 0, 0, 1, 0);
        chk("t2_acks", acc_q.size(), 4);
        chk("t2_req_full", 32'(mem_req), 0);
        cyc(0, 0, 0, 0, 1);
        repeat (10) cyc(0, 0, 0, 1, 0);
        chk("t2_refill", acc_q.size(), 5);
        chk("t2_addr16", acc_at(4), 32'd16);
        // redirect while a request is pending
        do_reset(1); acc_q.delete();
        for (int n = 0; n < 20 && !(mem_req && mem_addr == 32'h8); n++) cyc(0, 0, 0, 1, 0);
        chk("t3_found", 32'(mem_req && mem_addr == 32'h8), 1);
        cyc(0, 1, 32'h100, 0, 0);
        chk("t3_hold1", mem_addr, 32'h8);
        chk("t3_flushed", 32'(instr_valid), 0);
        cyc(0, 0, 0, 0, 0);
        chk("t3_hold2", mem_addr, 32'h8);
        chk("t3_req_up", 32'(mem_req), 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("t3_new_req", 32'(mem_req), 1);
        chk("t3_new_addr", mem_addr, 32'h100);
        chk("t3_no_stale", 32'(instr_valid), 0);
        cyc(0, 0, 0, 1, 0);
        chk("t3_head_valid", 32'(instr_valid), 1);
        chk("t3_head_pc", instr_pc, 32'h100);
        chk("t3_acc", acc_at(2), 32'h100);
        // redirect with same-cycle ack and pop
        do_reset(1);
        for (int n = 0; n < 20 && !(instr_valid && mem_req); n++) cyc(0, 0, 0, 1, 1);
        chk("t4_head", instr_pc, 32'h0);
        chk("t4_addr", mem_addr, 32'h4);
        cyc(0, 1, 32'h200, 1, 1);
        chk("t4_empty", 32'(instr_valid), 0);
        chk("t4_req", 32'(mem_req), 1);
        chk("t4_redir_addr", mem_addr, 32'h200);
        // unaligned target near the top of the address space
        do_reset(1); acc_q.delete();
        cyc(0, 1, 32'hFFFF_FFFE, 0, 1);
        repeat (8) cyc(0, 0, 0, 1, 1);
        chk("t5_top", acc_at(0), 32'hFFFF_FFFC);
        chk("t5_wrap", acc_at(1), 32'h0);
        // reset while dropping
        do_reset(1);
        for (int n = 0; n < 10 && !mem_req; n++) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 32'h300, 0, 0);
        chk("t6_drop_req", 32'(mem_req), 1);
        cyc(1, 0, 0, 0, 0);
        chk("t6_req_off", 32'(mem_req), 0);
        acc_q.delete();
        cyc(0, 0, 0, 2, 0);
        chk("t6_stray", 32'(instr_valid), 0);
        repeat (4) cyc(0, 0, 0, 1, 1);
        chk("t6_first", acc_at(0), 32'h0);
        // randomized traffic
        acc_total = 0;
        for (int i = 0; i < 4000; i++) begin
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cyc($urandom_range(0, 599) == 0, $urandom_range(0, 15) == 0, rp,
                ($urandom_range(0, 3) != 0) ? 1 : (($urandom_range(0, 7) == 0) ? 2 : 0),
                $urandom_range(0, 2) != 0);
        end
        chk("progress", 32'(acc_total > 500), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
